tbus_arbiter: RTL and testbench

//  Round-robin arbiter for the MCU's shared tristate data bus. Each requester

---
 rtl/tbus_arbiter_pkg.sv | 19 +
 rtl/tbus_arbiter_rr_pick.sv | 29 ++
 rtl/tbus_arbiter.sv | 110 +++++++++++
 tb/tb_tbus_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tbus_arbiter_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
// State encodings, default sizing and a counter-width helper.
package tbus_arbiter_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_TURN_CYC = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tbus_arbiter_rr_pick.sv
// Round-robin picker: first requester after last, wrapping mod N.
// Purely combinational.
module tbus_arbiter_rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           any,
  output logic [IDW-1:0] win
);

  function automatic logic [IDW-1:0] slot(
    input logic [IDW-1:0] base,
    input int             off
  );
    return IDW'((int'(base) + off) % N);
  endfunction

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = |req;
    win = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[slot(last, i)]) win = slot(last, i);
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner select for the shared tristate bus.
// Registered one-hot enables with a turnaround gap between owners.
module tbus_arbiter
  import tbus_arbiter_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  parameter  int TURN_CYC = DEF_TURN_CYC,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  localparam int HW = cnt_w(MAX_HOLD);
  localparam int TW = cnt_w(TURN_CYC);

  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_TOP = TW'(TURN_CYC - 1);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state;
  logic [IDW-1:0] last;
  logic [HW-1:0]  hold_cnt;
  logic [TW-1:0]  turn_cnt;

  logic           pick_any;
  logic [IDW-1:0] pick_win;
  logic [N-1:0]   win_mask;
  logic           owner_req;
  logic           others_wait;
  logic           release_bus;

  tbus_arbiter_rr_pick #(
    .N (N)
  ) u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign win_mask    = ONE << pick_win;
  assign owner_req   = req[gnt_id];
  assign others_wait = |(req & ~gnt);

  // Preempt only when someone else is actually waiting.
  assign release_bus = !owner_req ||
                       (hold_cnt == HOLD_TOP && others_wait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      last     <= IDW'(N - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            state    <= S_GRANT;
            gnt      <= win_mask;
            gnt_id   <= pick_win;
            busy     <= 1'b1;
            last     <= pick_win;
            hold_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (release_bus) begin
            state    <= S_TURN;
            gnt      <= '0;
            busy     <= 1'b0;
            turn_cnt <= '0;
          end else if (hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (turn_cnt != TURN_TOP) begin
            turn_cnt <= turn_cnt + 1'b1;
          end else if (pick_any) begin
            state    <= S_GRANT;
            gnt      <= win_mask;
            gnt_id   <= pick_win;
            busy     <= 1'b1;
            last     <= pick_win;
            hold_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter: directed phases then random traffic.
// A cycle model predicts each edge; the DUT result is popped and compared.
module tb_tbus_arbiter;
  import tbus_arbiter_pkg::*;

  localparam int N     = DEF_N;
  localparam int MH    = DEF_MAX_HOLD;
  localparam int TC    = DEF_TURN_CYC;
  localparam int IDW   = $clog2(N);
  localparam int BOUND = (N - 1) * (MH + TC) + 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  typedef struct {
    logic [N-1:0] gnt;
    logic         busy;
    int           id;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int m_owner, m_held, m_gap, m_last;
  int wcnt[N];
  int maxw = 0;

  tbus_arbiter #(
    .N        (N),
    .MAX_HOLD (MH),
    .TURN_CYC (TC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      a_onehot: assert ($onehot0(gnt));
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
  endtask

  function automatic int m_pick(input logic [N-1:0] r);
    int j;
    j = m_last;
    repeat (N) begin
      j = (j + 1) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_edge(input logic [N-1:0] r);
    int  w;
    logic [N-1:0] mine;
    bit  arb;
    arb = 1'b0;
    if (m_owner >= 0) begin
      mine = N'(1) << m_owner;
      if (!r[m_owner] || (m_held >= MH && (r & ~mine) != '0)) begin
        m_owner = -1;
        m_gap   = TC;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      arb = (m_gap == 0);
    end else begin
      arb = 1'b1;
    end
    if (arb) begin
      w = m_pick(r);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    exp_t e;
    @(negedge clk);
    req = r;
    m_edge(r);
    e.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.busy = (m_owner >= 0);
    e.id   = m_owner;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt", 32'(gnt), 32'(e.gnt));
    chk("busy", 32'(busy), 32'(e.busy));
    if (e.busy) chk("gnt_id", 32'(gnt_id), 32'(e.id));
    for (int i = 0; i < N; i++) begin
      if (r[i] && !gnt[i]) wcnt[i]++;
      else wcnt[i] = 0;
      if (wcnt[i] > maxw) maxw = wcnt[i];
    end
  endtask

  initial begin
    logic [N-1:0] cur;
    m_reset();
    req = 4'b1111;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(gnt_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(4'b1111);
    chk("first_gnt", 32'(gnt), 32'h1);
    repeat (74) step(4'b1111);
    repeat (3) step(4'b0000);

    repeat (5) step(4'b0100);
    repeat (3) step(4'b0000);

    repeat (50) step(4'b0001);
    repeat (30) step(4'b0101);
    repeat (3) step(4'b0000);

    repeat (3) step(4'b0010);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_busy", 32'(busy), 0);
    m_reset();
    @(negedge clk);
    req = 4'b0011;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0011);
    chk("restart_gnt", 32'(gnt), 32'h1);
    repeat (5) step(4'b0011);
    repeat (3) step(4'b0000);

    cur = '0;
    repeat (10000) begin
      for (int i = 0; i < N; i++) begin
        if (!cur[i]) begin
          if ($urandom_range(0, 3) == 0) cur[i] = 1'b1;
        end else if (m_owner == i && $urandom_range(0, 7) == 0) begin
          cur[i] = 1'b0;
        end
      end
      step(cur);
    end

    chk("wait_bound", 32'(maxw <= BOUND), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
